// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Summary  : Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the custom
//            ISA. It decodes ins[OP_MSB -: OP_W] and drives the datapath
//            enables for each state. It also provides a memory wait-state
//            handshake, a global stall, a retire counter and illegal-opcode
//            detection.
// Options  : ILLEGAL_TRAP_EN - when defined, an illegal opcode parks the FSM
//            in TRAP until reset. When undefined, the opcode is a NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int INS_W  = 32,
    parameter int OP_MSB = 31,
    parameter int OP_W   = 6,
    parameter int ALU_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INS_W-1:0] i_ins,
    input  logic             i_mem_ready,
    input  logic             i_stall,
    output logic             o_mem_req,
    output logic             o_iord,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_branch_en,
    output logic             o_jump,
    output logic             o_jump_reg,
    output logic             o_alu_src,
    output logic [ALU_W-1:0] o_alu_control,
    output logic             o_reg_dst,
    output logic             o_reg_write,
    output logic             o_mem_to_reg,
    output logic             o_link,
    output logic             o_retire,
    output logic [CNT_W-1:0] o_instr_count,
    output logic             o_illegal
);

    // Opcode constants, resized to the configured opcode width
    localparam logic [OP_W-1:0] c_OP_AND  = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] c_OP_NOR  = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] c_OP_NOT  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] c_OP_ROLV = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_OP_RORV = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] c_OP_NORI = OP_W'(6'b001110);
    localparam logic [OP_W-1:0] c_OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] c_OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] c_OP_JR   = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] c_OP_JAL  = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] c_OP_BLEU = OP_W'(6'b010000);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_count;

    logic [OP_W-1:0]  w_op;
    logic             w_is_r, w_is_nori, w_is_lw, w_is_sw;
    logic             w_is_jr, w_is_jal, w_is_bleu, w_legal;

    // Raw (ungated) control values produced by the FSM decode
    logic             w_mem_req, w_iord, w_mem_read, w_mem_write;
    logic             w_ir_write, w_pc_write, w_branch_en;
    logic             w_jump, w_jump_reg, w_alu_src;
    logic [ALU_W-1:0] w_alu_ctl;
    logic             w_reg_dst, w_reg_write, w_mem_to_reg, w_link;
    logic             w_retire, w_illegal;
    logic             w_run, w_en;

    // Only the opcode field is decoded; the remaining bits feed the datapath
    logic             w_unused_ins;
    assign w_unused_ins = ^i_ins;

    assign w_op      = i_ins[OP_MSB -: OP_W];
    assign w_is_r    = (w_op == c_OP_AND)  || (w_op == c_OP_NOR) ||
                       (w_op == c_OP_NOT)  || (w_op == c_OP_ROLV) ||
                       (w_op == c_OP_RORV);
    assign w_is_nori = (w_op == c_OP_NORI);
    assign w_is_lw   = (w_op == c_OP_LW);
    assign w_is_sw   = (w_op == c_OP_SW);
    assign w_is_jr   = (w_op == c_OP_JR);
    assign w_is_jal  = (w_op == c_OP_JAL);
    assign w_is_bleu = (w_op == c_OP_BLEU);
    assign w_legal   = w_is_r | w_is_nori | w_is_lw | w_is_sw |
                       w_is_jr | w_is_jal | w_is_bleu;

    // State register: reset aborts any instruction; stall freezes the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else if (!i_stall) begin
            r_state <= w_next;
        end
    end

    // Retire counter advances on the edge that closes a retire cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (o_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    // Next-state and raw control decode from state, opcode and mem_ready
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch_en  = 1'b0;
        w_jump       = 1'b0;
        w_jump_reg   = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_ctl    = '0;
        w_reg_dst    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_link       = 1'b0;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_mem_read = 1'b1;
                w_ir_write = i_mem_ready;
                w_pc_write = i_mem_ready;
                if (i_mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                    w_next    = S_TRAP;
`else
                    w_next    = S_FETCH;
`endif
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_ctl = i_ins[OP_MSB -: ALU_W];
                w_alu_src = w_is_nori | w_is_lw | w_is_sw;
                if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else if (w_is_bleu) begin
                    w_branch_en = 1'b1;
                    w_retire    = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_is_jr) begin
                    w_pc_write = 1'b1;
                    w_jump     = 1'b1;
                    w_jump_reg = 1'b1;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end else if (w_is_jal) begin
                    w_pc_write = 1'b1;
                    w_jump     = 1'b1;
                    w_next     = S_WB;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_iord      = 1'b1;
                w_mem_read  = w_is_lw;
                w_mem_write = w_is_sw;
                if (i_mem_ready) begin
                    if (w_is_sw) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = w_is_r;
                w_mem_to_reg = w_is_lw;
                w_link       = w_is_jal;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_illegal = 1'b1;
                w_next    = S_TRAP;
            end
`endif
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Everything is forced low during reset; stall also kills writes and requests
    assign w_run = rst_n;
    assign w_en  = rst_n & ~i_stall;

    assign o_mem_req     = w_en  & w_mem_req;
    assign o_iord        = w_run & w_iord;
    assign o_mem_read    = w_run & w_mem_read;
    assign o_mem_write   = w_en  & w_mem_write;
    assign o_ir_write    = w_en  & w_ir_write;
    assign o_pc_write    = w_en  & w_pc_write;
    assign o_branch_en   = w_en  & w_branch_en;
    assign o_jump        = w_run & w_jump;
    assign o_jump_reg    = w_run & w_jump_reg;
    assign o_alu_src     = w_run & w_alu_src;
    assign o_alu_control = w_run ? w_alu_ctl : '0;
    assign o_reg_dst     = w_run & w_reg_dst;
    assign o_reg_write   = w_en  & w_reg_write;
    assign o_mem_to_reg  = w_run & w_mem_to_reg;
    assign o_link        = w_run & w_link;
    assign o_retire      = w_en  & w_retire;
    assign o_illegal     = w_run & w_illegal;
    assign o_instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Summary  : Directed bench for multicycle_control. Each step drives the
//            inputs in the low clock phase and then checks the control
//            vector, alu_control and the retire count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    // Control vector bit positions (see w_ctl packing below)
    localparam logic [15:0] MREQ = 16'h8000;
    localparam logic [15:0] IORD = 16'h4000;
    localparam logic [15:0] MRD  = 16'h2000;
    localparam logic [15:0] MWR  = 16'h1000;
    localparam logic [15:0] IRW  = 16'h0800;
    localparam logic [15:0] PCW  = 16'h0400;
    localparam logic [15:0] BR   = 16'h0200;
    localparam logic [15:0] JMP  = 16'h0100;
    localparam logic [15:0] JR   = 16'h0080;
    localparam logic [15:0] ASRC = 16'h0040;
    localparam logic [15:0] RDST = 16'h0020;
    localparam logic [15:0] RW   = 16'h0010;
    localparam logic [15:0] MTR  = 16'h0008;
    localparam logic [15:0] LNK  = 16'h0004;
    localparam logic [15:0] RET  = 16'h0002;
    localparam logic [15:0] ILL  = 16'h0001;
    localparam logic [15:0] NONE = 16'h0000;
    localparam logic [15:0] FE   = MREQ | MRD | IRW | PCW;
    localparam logic [15:0] FW   = MREQ | MRD;

    localparam logic [31:0] I_AND  = 32'h8000_0000;
    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_JR   = 32'h2000_0000;
    localparam logic [31:0] I_BLEU = 32'h4000_0000;
    localparam logic [31:0] I_NORI = 32'h3800_0000;
    localparam logic [31:0] I_BAD  = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_ins;
    logic        i_mem_ready;
    logic        i_stall;

    logic        o_mem_req, o_iord, o_mem_read, o_mem_write, o_ir_write;
    logic        o_pc_write, o_branch_en, o_jump, o_jump_reg, o_alu_src;
    logic [4:0]  o_alu_control;
    logic        o_reg_dst, o_reg_write, o_mem_to_reg, o_link, o_retire;
    logic [31:0] o_instr_count;
    logic        o_illegal;

    // Narrow-counter instance: only its count is checked (wrap boundary)
    logic [20:0] s_unused_ctl;
    logic [2:0]  s_count3;

    logic [15:0] w_ctl;
    int          checks   = 0;
    int          failures = 0;

    assign w_ctl = {o_mem_req, o_iord, o_mem_read, o_mem_write, o_ir_write,
                    o_pc_write, o_branch_en, o_jump, o_jump_reg, o_alu_src,
                    o_reg_dst, o_reg_write, o_mem_to_reg, o_link, o_retire,
                    o_illegal};

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ins         (i_ins),
        .i_mem_ready   (i_mem_ready),
        .i_stall       (i_stall),
        .o_mem_req     (o_mem_req),
        .o_iord        (o_iord),
        .o_mem_read    (o_mem_read),
        .o_mem_write   (o_mem_write),
        .o_ir_write    (o_ir_write),
        .o_pc_write    (o_pc_write),
        .o_branch_en   (o_branch_en),
        .o_jump        (o_jump),
        .o_jump_reg    (o_jump_reg),
        .o_alu_src     (o_alu_src),
        .o_alu_control (o_alu_control),
        .o_reg_dst     (o_reg_dst),
        .o_reg_write   (o_reg_write),
        .o_mem_to_reg  (o_mem_to_reg),
        .o_link        (o_link),
        .o_retire      (o_retire),
        .o_instr_count (o_instr_count),
        .o_illegal     (o_illegal)
    );

    multicycle_control #(.CNT_W(3)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ins         (i_ins),
        .i_mem_ready   (i_mem_ready),
        .i_stall       (i_stall),
        .o_mem_req     (s_unused_ctl[0]),
        .o_iord        (s_unused_ctl[1]),
        .o_mem_read    (s_unused_ctl[2]),
        .o_mem_write   (s_unused_ctl[3]),
        .o_ir_write    (s_unused_ctl[4]),
        .o_pc_write    (s_unused_ctl[5]),
        .o_branch_en   (s_unused_ctl[6]),
        .o_jump        (s_unused_ctl[7]),
        .o_jump_reg    (s_unused_ctl[8]),
        .o_alu_src     (s_unused_ctl[9]),
        .o_alu_control (s_unused_ctl[14:10]),
        .o_reg_dst     (s_unused_ctl[15]),
        .o_reg_write   (s_unused_ctl[16]),
        .o_mem_to_reg  (s_unused_ctl[17]),
        .o_link        (s_unused_ctl[18]),
        .o_retire      (s_unused_ctl[19]),
        .o_instr_count (s_count3),
        .o_illegal     (s_unused_ctl[20])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the outputs as they are now (no clock movement)
    task automatic now(input string tag, input logic [15:0] ectl, input logic [4:0] ealu,
                       input logic [31:0] ecnt);
        chk({tag, ".ctl"}, 32'(w_ctl), 32'(ectl));
        chk({tag, ".alu"}, 32'(o_alu_control), 32'(ealu));
        chk({tag, ".cnt"}, o_instr_count, ecnt);
        chk({tag, ".cnt3"}, 32'(s_count3), ecnt & 32'd7);
    endtask

    // One clock step: drive in the low phase, then check before the next edge
    task automatic cyc(input string tag, input logic [31:0] ins, input logic rdy,
                       input logic stl, input logic [15:0] ectl, input logic [4:0] ealu,
                       input logic [31:0] ecnt);
        @(negedge clk);
        i_ins       = ins;
        i_mem_ready = rdy;
        i_stall     = stl;
        #1;
        now(tag, ectl, ealu, ecnt);
    endtask

    initial begin
        rst_n       = 1'b1;
        i_ins       = 32'h0;
        i_mem_ready = 1'b0;
        i_stall     = 1'b0;
        #2 rst_n    = 1'b0;
        #1 now("reset_async", NONE, 5'h00, 0);
        cyc("reset_hold0", I_AND, 1'b1, 1'b0, NONE, 5'h00, 0);
        cyc("reset_hold1", I_AND, 1'b1, 1'b0, NONE, 5'h00, 0);
        i_mem_ready = 1'b0;
        rst_n       = 1'b1;
        #1 now("reset_release", FW, 5'h00, 0);

        // and: F D E W
        cyc("and_F", I_AND, 1'b1, 1'b0, FE, 5'h00, 0);
        cyc("and_D", I_AND, 1'b1, 1'b0, NONE, 5'h00, 0);
        cyc("and_E", I_AND, 1'b1, 1'b0, NONE, 5'h10, 0);
        cyc("and_W", I_AND, 1'b1, 1'b0, RDST | RW | RET, 5'h00, 0);
        cyc("fetch_wait", I_LW, 1'b0, 1'b0, FW, 5'h00, 1);

        // lw with two memory wait cycles: 7 cycles total
        cyc("lw_F", I_LW, 1'b1, 1'b0, FE, 5'h00, 1);
        cyc("lw_D", I_LW, 1'b1, 1'b0, NONE, 5'h00, 1);
        cyc("lw_E", I_LW, 1'b1, 1'b0, ASRC, 5'h11, 1);
        cyc("lw_M0", I_LW, 1'b0, 1'b0, MREQ | IORD | MRD, 5'h00, 1);
        cyc("lw_M1", I_LW, 1'b0, 1'b0, MREQ | IORD | MRD, 5'h00, 1);
        cyc("lw_M2", I_LW, 1'b1, 1'b0, MREQ | IORD | MRD, 5'h00, 1);
        cyc("lw_W", I_LW, 1'b1, 1'b0, RW | MTR | RET, 5'h00, 1);

        // jal
        cyc("jal_F", I_JAL, 1'b1, 1'b0, FE, 5'h00, 2);
        cyc("jal_D", I_JAL, 1'b1, 1'b0, NONE, 5'h00, 2);
        cyc("jal_E", I_JAL, 1'b1, 1'b0, PCW | JMP, 5'h01, 2);
        cyc("jal_W", I_JAL, 1'b1, 1'b0, RW | LNK | RET, 5'h00, 2);

        // jr: 3 cycles
        cyc("jr_F", I_JR, 1'b1, 1'b0, FE, 5'h00, 3);
        cyc("jr_D", I_JR, 1'b1, 1'b0, NONE, 5'h00, 3);
        cyc("jr_E", I_JR, 1'b1, 1'b0, PCW | JMP | JR | RET, 5'h04, 3);

        // bleu: 3 cycles
        cyc("bleu_F", I_BLEU, 1'b1, 1'b0, FE, 5'h00, 4);
        cyc("bleu_D", I_BLEU, 1'b1, 1'b0, NONE, 5'h00, 4);
        cyc("bleu_E", I_BLEU, 1'b1, 1'b0, BR | RET, 5'h08, 4);

        // sw, no wait
        cyc("sw_F", I_SW, 1'b1, 1'b0, FE, 5'h00, 5);
        cyc("sw_D", I_SW, 1'b1, 1'b0, NONE, 5'h00, 5);
        cyc("sw_E", I_SW, 1'b1, 1'b0, ASRC, 5'h15, 5);
        cyc("sw_M", I_SW, 1'b1, 1'b0, MREQ | IORD | MWR | RET, 5'h00, 5);

        // nori
        cyc("nori_F", I_NORI, 1'b1, 1'b0, FE, 5'h00, 6);
        cyc("nori_D", I_NORI, 1'b1, 1'b0, NONE, 5'h00, 6);
        cyc("nori_E", I_NORI, 1'b1, 1'b0, ASRC, 5'h07, 6);
        cyc("nori_W", I_NORI, 1'b1, 1'b0, RW | RET, 5'h00, 6);

        // stall beats mem_ready in FETCH, then a stalled WB
        cyc("stall_F0", I_AND, 1'b1, 1'b1, MRD, 5'h00, 7);
        cyc("stall_F1", I_AND, 1'b1, 1'b1, MRD, 5'h00, 7);
        cyc("stall_F2", I_AND, 1'b1, 1'b1, MRD, 5'h00, 7);
        cyc("stall_F", I_AND, 1'b1, 1'b0, FE, 5'h00, 7);
        cyc("stall_D", I_AND, 1'b1, 1'b0, NONE, 5'h00, 7);
        cyc("stall_E", I_AND, 1'b1, 1'b0, NONE, 5'h10, 7);
        cyc("stall_W0", I_AND, 1'b1, 1'b1, RDST, 5'h00, 7);
        cyc("stall_W", I_AND, 1'b1, 1'b0, RDST | RW | RET, 5'h00, 7);

        // reset in the MEM state of sw (count 8; narrow counter wrapped 7 -> 0)
        cyc("swr_F", I_SW, 1'b1, 1'b0, FE, 5'h00, 8);
        cyc("swr_D", I_SW, 1'b1, 1'b0, NONE, 5'h00, 8);
        cyc("swr_E", I_SW, 1'b1, 1'b0, ASRC, 5'h15, 8);
        cyc("swr_M", I_SW, 1'b0, 1'b0, MREQ | IORD | MWR, 5'h00, 8);
        rst_n = 1'b0;
        #1 now("swr_rst", NONE, 5'h00, 0);
        i_mem_ready = 1'b0;
        rst_n       = 1'b1;
        #1 now("swr_release", FW, 5'h00, 0);

        cyc("jr2_F", I_JR, 1'b1, 1'b0, FE, 5'h00, 0);
        cyc("jr2_D", I_JR, 1'b1, 1'b0, NONE, 5'h00, 0);
        cyc("jr2_E", I_JR, 1'b1, 1'b0, PCW | JMP | JR | RET, 5'h04, 0);

        // illegal opcode
        cyc("ill_F", I_BAD, 1'b1, 1'b0, FE, 5'h00, 1);
        cyc("ill_D", I_BAD, 1'b1, 1'b0, ILL, 5'h00, 1);
`ifdef ILLEGAL_TRAP_EN
        cyc("trap0", I_BAD, 1'b1, 1'b0, ILL, 5'h00, 1);
        cyc("trap1", I_AND, 1'b1, 1'b0, ILL, 5'h00, 1);
        rst_n = 1'b0;
        #1 now("trap_rst", NONE, 5'h00, 0);
        i_mem_ready = 1'b0;
        rst_n       = 1'b1;
        #1 now("trap_release", FW, 5'h00, 0);
`else
        cyc("ill_next", I_AND, 1'b0, 1'b0, FW, 5'h00, 1);
        cyc("ill_after", I_AND, 1'b1, 1'b0, FE, 5'h00, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
